// File: rtl/branch_predictor_if.sv
// Query/update/statistics bundle between the CPU pipeline and the branch predictor.
// Signal names are given from the predictor's point of view.
interface branch_predictor_if;
    logic [31:0] query_pc_i;
    logic        predict_taken_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        actual_taken_i;
    logic        predicted_taken_i;
    logic        mispredict_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    modport master (
        output query_pc_i,
        output update_valid_i,
        output update_pc_i,
        output actual_taken_i,
        output predicted_taken_i,
        input  predict_taken_o,
        input  mispredict_o,
        input  branch_cnt_o,
        input  mispredict_cnt_o
    );

    modport slave (
        input  query_pc_i,
        input  update_valid_i,
        input  update_pc_i,
        input  actual_taken_i,
        input  predicted_taken_i,
        output predict_taken_o,
        output mispredict_o,
        output branch_cnt_o,
        output mispredict_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch history table with mispredict flag and
// saturating branch/mispredict statistics counters.
module branch_predictor #(
    parameter int unsigned ENTRIES    = 16,
    parameter logic [1:0]  INIT_STATE = 2'b10
) (
    input logic                clk_i,
    input logic                rst_i,
    input logic                start_i,
    branch_predictor_if.slave  bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       bht_d [ENTRIES];
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] query_idx;
    logic [IDX_W-1:0] update_idx;
    logic             update_accept;
    logic             mispredict;
    logic [1:0]       upd_state;
    logic [1:0]       upd_state_next;

    // Byte offset and bits above the index never select an entry (no tags).
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{bp.query_pc_i[31:IDX_W+2], bp.query_pc_i[1:0],
                              bp.update_pc_i[31:IDX_W+2], bp.update_pc_i[1:0]};

    assign query_idx  = bp.query_pc_i[IDX_W+1:2];
    assign update_idx = bp.update_pc_i[IDX_W+1:2];

    assign update_accept = bp.update_valid_i && start_i && !rst_i;
    assign mispredict    = update_accept && (bp.actual_taken_i != bp.predicted_taken_i);

    // Query reads the registered table, so a same-cycle update is not bypassed.
    assign bp.predict_taken_o  = bht_q[query_idx][1];
    assign bp.mispredict_o     = mispredict;
    assign bp.branch_cnt_o     = branch_cnt_q;
    assign bp.mispredict_cnt_o = mispredict_cnt_q;

    assign upd_state = bht_q[update_idx];

    always_comb begin
        upd_state_next = upd_state;
        if (bp.actual_taken_i) begin
            if (upd_state != 2'b11) begin
                upd_state_next = upd_state + 2'b01;
            end
        end else begin
            if (upd_state != 2'b00) begin
                upd_state_next = upd_state - 2'b01;
            end
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (update_accept) begin
            bht_d[update_idx] = upd_state_next;
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_accept && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                bht_q[i] <= INIT_STATE;
            end
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            bht_q            <= bht_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end
endmodule
